// File: rtl/riscv_pkg.sv
// Shared definitions for the boot loader: data-path width and loader state encoding.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    HDR0,
    HDR1,
    LOAD,
    CHK,
    DONE,
    ERR
  } load_state_t;

endpackage

// File: rtl/word_assembler.sv
// Shifts in four accepted bytes (first byte lands in bits [7:0]) and presents the
// completed 32-bit word together with a one-cycle word_valid pulse on the next cycle.
module word_assembler
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      byte_data,
  input  logic            byte_valid,
  output logic [1:0]      byte_idx,
  output logic [XLEN-1:0] word,
  output logic            word_valid
);

  logic [23:0] shift_p0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_p0   <= '0;
      byte_idx   <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (byte_valid) begin
        shift_p0 <= {byte_data, shift_p0[23:8]};
        byte_idx <= byte_idx + 2'd1;
        // Stage boundary: the fourth byte completes the word, published next cycle.
        if (byte_idx == 2'd3) begin
          word       <= {byte_data, shift_p0};
          word_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/program_loader.sv
// Boot loader: 16-bit word-count header, little-endian payload words into IMEM, core held in reset until done.
// Optional trailing checksum byte when LOADER_CHECKSUM_EN is defined.
module program_loader
  import riscv_pkg::*;
#(
  parameter int              IMEM_DEPTH = 64,
  parameter logic [XLEN-1:0] BASE_ADDR  = '0,
  parameter int              CNT_W      = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      rx_data,
  input  logic            rx_valid,
  output logic            rx_ready,
  output logic            imem_we,
  output logic [XLEN-1:0] imem_addr,
  output logic [XLEN-1:0] imem_wdata,
  output logic            core_reset_n,
  output logic            load_done,
  output logic            load_error
);

  load_state_t      state;
  logic [7:0]       count_lo;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] word_idx;
  logic [CNT_W-1:0] hdr_n;
  logic [1:0]       byte_idx;
  logic             accept;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]       csum;
`endif

  assign accept = rx_valid & rx_ready;
  assign hdr_n  = CNT_W'({rx_data, count_lo});

  word_assembler u_word_assembler (
    .clk        (clk),
    .reset      (reset),
    .byte_data  (rx_data),
    .byte_valid (accept && (state == LOAD)),
    .byte_idx   (byte_idx),
    .word       (imem_wdata),
    .word_valid (imem_we)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= HDR0;
      rx_ready     <= 1'b0;
      core_reset_n <= 1'b0;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
      imem_addr    <= '0;
      count_lo     <= '0;
      count        <= '0;
      word_idx     <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      case (state)
        HDR0: begin
          rx_ready <= 1'b1;
          if (accept) begin
            count_lo <= rx_data;
            state    <= HDR1;
          end
        end
        HDR1: begin
          if (accept) begin
            count <= hdr_n;
            if (hdr_n == '0) begin
`ifdef LOADER_CHECKSUM_EN
              state <= CHK;
`else
              state        <= DONE;
              rx_ready     <= 1'b0;
              core_reset_n <= 1'b1;
              load_done    <= 1'b1;
`endif
            end else if (int'(hdr_n) > IMEM_DEPTH) begin
              state      <= ERR;
              rx_ready   <= 1'b0;
              load_error <= 1'b1;
            end else begin
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (accept) begin
`ifdef LOADER_CHECKSUM_EN
            csum <= csum + rx_data;
`endif
            // Address is registered alongside the assembled word so both appear with imem_we.
            if (byte_idx == 2'd3) begin
              imem_addr <= BASE_ADDR + (XLEN'(word_idx) << 2);
              word_idx  <= word_idx + CNT_W'(1);
              if (word_idx == count - CNT_W'(1)) begin
`ifdef LOADER_CHECKSUM_EN
                state <= CHK;
`else
                state        <= DONE;
                rx_ready     <= 1'b0;
                core_reset_n <= 1'b1;
                load_done    <= 1'b1;
`endif
              end
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CHK: begin
          if (accept) begin
            rx_ready <= 1'b0;
            if (rx_data == csum) begin
              state        <= DONE;
              core_reset_n <= 1'b1;
              load_done    <= 1'b1;
            end else begin
              state      <= ERR;
              load_error <= 1'b1;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
